dds_multi: RTL

- Multi-channel, pipelined direct digital synthesiser. NCH independent channels, each with its own frequency word, phase offset and amplitude.
- Uses a quarter-wave sine ROM per channel, plus a global phase-sync strobe for coherent restart.
- Feeds the DAC/FIR datapath with signed samples and a sample-valid flag.

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_multi_if.sv | 28 ++
 rtl/dds_quarter_rom.sv | 46 ++++
 rtl/dds_multi.sv | 101 ++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the multi-channel DDS: quadrant codes, pipeline depth
// and the rounding constant used by the amplitude scaler.
package dds_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam int unsigned DDS_LAT = 4;

  // Half-LSB of the amplitude scale, added before the arithmetic right shift.
  function automatic int unsigned rnd(input int unsigned amp_w);
    return 32'd1 << (amp_w - 1);
  endfunction

endpackage

// File: rtl/dds_multi_if.sv
// Control/sample bus of the multi-channel DDS; per-channel fields are packed
// with channel c at [c*W +: W].
interface dds_multi_if #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned AMP_W   = 8,
  parameter int unsigned NCH     = 2
);

  logic                   ClkEn;
  logic                   SyncReq;
  logic [NCH*PHASE_W-1:0] FreqWord;
  logic [NCH*PHASE_W-1:0] PhaseShift;
  logic [NCH*AMP_W-1:0]   Amp;
  logic [NCH*DATA_W-1:0]  Out;
  logic                   OutValid;

  modport master (
    output ClkEn, SyncReq, FreqWord, PhaseShift, Amp,
    input  Out, OutValid
  );

  modport slave (
    input  ClkEn, SyncReq, FreqWord, PhaseShift, Amp,
    output Out, OutValid
  );

endinterface

// File: rtl/dds_quarter_rom.sv
// Quarter-wave sine magnitude ROM with registered read; table computed at
// elaboration. MEM_FILE is retained for interface compatibility.
module dds_quarter_rom #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned TABLE_AW = 10,
  parameter string       MEM_FILE = "QuarterSine.dat"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TABLE_AW-1:0] addr,
  output logic [DATA_W-2:0]   mag
);

  localparam int unsigned DEPTH = 2 ** TABLE_AW;

  logic [DATA_W-2:0] rom [DEPTH];

  // Entry i samples sin at (i+0.5)*pi/2^(TABLE_AW+1); the half-step offset makes
  // the mirrored (inverted-address) read land on the exact complementary angle.
  function automatic logic [DATA_W-2:0] sine_entry(input int unsigned i);
    real x;
    real term;
    real sum;
    real full;
    x    = (2.0 * i + 1.0) * 3.14159265358979323846 / (4.0 * DEPTH);
    term = x;
    sum  = x;
    for (int unsigned k = 1; k < 12; k++) begin
      term = -term * x * x / ((2.0 * k) * (2.0 * k + 1.0));
      sum  = sum + term;
    end
    full = ((1 << (DATA_W - 1)) - 1) * sum;
    return (DATA_W-1)'($rtoi(full + 0.5));
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    localparam logic [DATA_W-2:0] V = sine_entry(i);
    assign rom[i] = V;
  end

  always_ff @(posedge clk) begin
    if (rst) mag <= '0;
    else     mag <= rom[addr];
  end

endmodule

// File: rtl/dds_multi.sv
// Multi-channel pipelined DDS: per-channel phase accumulator, quarter-wave fold,
// ROM lookup, sign restore and rounded amplitude scaling; 4-stage valid pipe.
module dds_multi
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned TABLE_AW = 10,
  parameter int unsigned AMP_W    = 8,
  parameter int unsigned NCH      = 2,
  parameter string       MEM_FILE = "QuarterSine.dat"
) (
  input logic      clk,
  input logic      rst,
  dds_multi_if.slave bus
);

  localparam int unsigned           PW  = DATA_W + AMP_W + 1;
  localparam logic signed [PW-1:0]  RND = PW'(rnd(AMP_W));

  logic [DDS_LAT-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else     vld <= {vld[DDS_LAT-2:0], bus.ClkEn};
  end

  assign bus.OutValid = vld[DDS_LAT-1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PHASE_W-1:0]       phase_q;
    logic [PHASE_W-1:0]       p;
    logic [PHASE_W-1:0]       a;
    quad_e                    quad;
    logic                     unused_lsb;
    logic [TABLE_AW-1:0]      idx1;
    logic                     neg1, neg2;
    logic [AMP_W-1:0]         amp1, amp2, amp3;
    logic [DATA_W-2:0]        mag;
    logic signed [DATA_W-1:0] mag_s;
    logic signed [DATA_W-1:0] s3;
    logic signed [PW-1:0]     prod;
    logic [DATA_W-1:0]        out_q;

    always_comb begin
      p          = bus.SyncReq ? '0 : phase_q;
      a          = p + bus.PhaseShift[c*PHASE_W +: PHASE_W];
      quad       = quad_e'(a[PHASE_W-1 -: 2]);
      unused_lsb = ^a[PHASE_W-TABLE_AW-3:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_q <= '0;
        idx1    <= '0;
        neg1    <= 1'b0;
        amp1    <= '0;
      end else begin
        phase_q <= p + (bus.ClkEn ? bus.FreqWord[c*PHASE_W +: PHASE_W] : '0);
        // Odd quadrants walk the quarter table backwards; the lower half negates.
        idx1    <= (quad inside {Q1, Q3}) ? ~a[PHASE_W-3 -: TABLE_AW]
                                          :  a[PHASE_W-3 -: TABLE_AW];
        neg1    <= quad inside {Q2, Q3};
        amp1    <= bus.Amp[c*AMP_W +: AMP_W];
      end
    end

    dds_quarter_rom #(
      .DATA_W  (DATA_W),
      .TABLE_AW(TABLE_AW),
      .MEM_FILE(MEM_FILE)
    ) u_rom (
      .clk (clk),
      .rst (rst),
      .addr(idx1),
      .mag (mag)
    );

    assign mag_s = {1'b0, mag};
    assign prod  = PW'(s3) * PW'($signed({1'b0, amp3}));

    always_ff @(posedge clk) begin
      if (rst) begin
        neg2  <= 1'b0;
        amp2  <= '0;
        s3    <= '0;
        amp3  <= '0;
        out_q <= '0;
      end else begin
        neg2 <= neg1;
        amp2 <= amp1;
        s3   <= neg2 ? -mag_s : mag_s;
        amp3 <= amp2;
        if (vld[DDS_LAT-2]) out_q <= DATA_W'((prod + RND) >>> AMP_W);
      end
    end

    assign bus.Out[c*DATA_W +: DATA_W] = out_q;
  end

endmodule
